// File: rtl/mod_counter_pkg.sv
// ---------------------------------------------------------------------------
// mod_counter_pkg
//   Shared constants and types for the modulo up/down counter.
//
//   DIR_UP / DIR_DOWN   : encoding of the 'up' direction input
//   MODE_BIN / MODE_GRAY: encoding of the 'gray_mode' output-select input
//   action_e            : decoded per-edge action of the counter core
// ---------------------------------------------------------------------------
package mod_counter_pkg;

  // Direction input encoding.
  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  // Output-mode input encoding.
  localparam logic MODE_BIN  = 1'b0;
  localparam logic MODE_GRAY = 1'b1;

  // What the counter does on the next edge (reset is applied on top of this
  // inside the register process, so it has no entry here).
  typedef enum logic [2:0] {
    ACT_HOLD       = 3'd0,
    ACT_LOAD       = 3'd1,
    ACT_LOAD_CLAMP = 3'd2,
    ACT_STEP_UP    = 3'd3,
    ACT_STEP_DOWN  = 3'd4
  } action_e;

endpackage : mod_counter_pkg

// File: rtl/mod_counter_bin2gray.sv
// ---------------------------------------------------------------------------
// bin2gray
//   Purely combinational binary to reflected-Gray converter.
//
//   Parameters:
//     WIDTH : code width in bits
//   Ports:
//     bin   input  [WIDTH-1:0]  binary value
//     gray  output [WIDTH-1:0]  Gray code of bin (bin ^ (bin >> 1))
// ---------------------------------------------------------------------------
module bin2gray #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] bin,
  output logic [WIDTH-1:0] gray
);

  import mod_counter_pkg::*;

  // The MSB passes straight through; every lower bit is the XOR of itself
  // and its upper neighbour.
  assign gray[WIDTH-1] = bin[WIDTH-1];

  generate
    for (genvar gi = 0; gi < WIDTH - 1; gi++) begin : g_xor
      assign gray[gi] = bin[gi] ^ bin[gi+1];
    end
  endgenerate

endmodule : bin2gray

// File: rtl/mod_counter.sv
// ---------------------------------------------------------------------------
// mod_counter
//   Loadable modulo-MODULUS up/down counter with binary or Gray output.
//
//   Parameters:
//     WIDTH   : state width in bits (2..16)
//     MODULUS : number of count states (2..2**WIDTH); count runs 0..MODULUS-1
//   Ports:
//     clock       input           single clock, rising edge
//     reset       input           synchronous active-high reset
//     enable      input           advance one step when high
//     up          input           1 = increment, 0 = decrement
//     load        input           load load_value this edge (beats enable)
//     load_value  input  [WIDTH]  binary value to load
//     gray_mode   input           0 = binary output, 1 = Gray output
//     count       output [WIDTH]  current count, binary or Gray
//     tc          output          combinational: next enabled step wraps
//     wrap        output          registered pulse the cycle after a wrap
//     load_err    output          registered pulse after an out-of-range load
// ---------------------------------------------------------------------------
module mod_counter
  import mod_counter_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             gray_mode,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             wrap,
  output logic             load_err
);

  // Highest legal state. MODULUS itself may equal 2**WIDTH, which does not
  // fit in WIDTH bits, so the range check is done one bit wider.
  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  logic [WIDTH-1:0] bin_reg,      bin_next;
  logic             wrap_reg,     wrap_next;
  logic             load_err_reg, load_err_next;

  // -------------------------------------------------------------------------
  // Decode helpers
  // -------------------------------------------------------------------------
  logic             at_max;
  logic             at_min;
  logic             load_in_range;
  logic [WIDTH-1:0] step_up_val;
  logic [WIDTH-1:0] step_down_val;
  action_e          action;

  assign at_max        = (bin_reg == MAX_VAL);
  assign at_min        = (bin_reg == '0);
  assign load_in_range = ({1'b0, load_value} < MOD_EXT);

  // The wrap cases are selected explicitly, so the WIDTH-bit +1 / -1 never
  // has to carry out, even when MODULUS = 2**WIDTH.
  assign step_up_val   = at_max ? '0      : bin_reg + WIDTH'(1);
  assign step_down_val = at_min ? MAX_VAL : bin_reg - WIDTH'(1);

  // Terminal count looks only at the live inputs and the register; it is
  // not gated by reset, which acts purely on the edge.
  assign tc = enable & ~load &
              (((up == DIR_UP)   & at_max) |
               ((up == DIR_DOWN) & at_min));

  // -------------------------------------------------------------------------
  // Action decode: load > enable > hold
  // -------------------------------------------------------------------------
  always_comb begin
    action = ACT_HOLD;
    if (load) begin
      action = load_in_range ? ACT_LOAD : ACT_LOAD_CLAMP;
    end else if (enable) begin
      action = (up == DIR_UP) ? ACT_STEP_UP : ACT_STEP_DOWN;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    bin_next      = bin_reg;
    wrap_next     = 1'b0;
    load_err_next = 1'b0;

    unique case (action)
      ACT_LOAD: begin
        bin_next = load_value;
      end
      ACT_LOAD_CLAMP: begin
        // An out-of-range value would break the 0..MODULUS-1 invariant, so
        // the counter restarts from zero and flags the bad load.
        bin_next      = '0;
        load_err_next = 1'b1;
      end
      ACT_STEP_UP: begin
        bin_next  = step_up_val;
        wrap_next = tc;
      end
      ACT_STEP_DOWN: begin
        bin_next  = step_down_val;
        wrap_next = tc;
      end
      default: begin
        bin_next = bin_reg;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // State register. Reset also clears the pulse flags, so any wrap or
  // load_err that would have followed this edge is dropped.
  // -------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      bin_reg      <= '0;
      wrap_reg     <= 1'b0;
      load_err_reg <= 1'b0;
    end else begin
      bin_reg      <= bin_next;
      wrap_reg     <= wrap_next;
      load_err_reg <= load_err_next;
    end
  end

  // -------------------------------------------------------------------------
  // Output path: Gray conversion straight off the register so that a change
  // of gray_mode is visible in the same cycle.
  // -------------------------------------------------------------------------
  logic [WIDTH-1:0] gray_val;

  bin2gray #(
    .WIDTH (WIDTH)
  ) u_bin2gray (
    .bin  (bin_reg),
    .gray (gray_val)
  );

  assign count    = (gray_mode == MODE_GRAY) ? gray_val : bin_reg;
  assign wrap     = wrap_reg;
  assign load_err = load_err_reg;

endmodule : mod_counter

// File: tb/tb_mod_counter.sv
// ---------------------------------------------------------------------------
// tb_mod_counter
//   Self-checking bench for mod_counter. Instance dut_a uses WIDTH=4,
//   MODULUS=10; instance dut_b uses WIDTH=4, MODULUS=16. Both share clock
//   and reset. Inputs change on the falling edge; outputs are sampled on the
//   falling edge after the active rising edge.
// ---------------------------------------------------------------------------
module tb_mod_counter;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic       reset;
  logic       a_enable, a_up, a_load, a_gray;
  logic [3:0] a_lv, a_count;
  logic       a_tc, a_wrap, a_lerr;
  logic       b_enable, b_up, b_load, b_gray;
  logic [3:0] b_lv, b_count;
  logic       b_tc, b_wrap, b_lerr;

  mod_counter #(.WIDTH(4), .MODULUS(10)) dut_a (
    .clock(clock), .reset(reset), .enable(a_enable), .up(a_up),
    .load(a_load), .load_value(a_lv), .gray_mode(a_gray),
    .count(a_count), .tc(a_tc), .wrap(a_wrap), .load_err(a_lerr)
  );

  mod_counter #(.WIDTH(4), .MODULUS(16)) dut_b (
    .clock(clock), .reset(reset), .enable(b_enable), .up(b_up),
    .load(b_load), .load_value(b_lv), .gray_mode(b_gray),
    .count(b_count), .tc(b_tc), .wrap(b_wrap), .load_err(b_lerr)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state, one per instance.
  int m_bin [2] = '{0, 0};
  int m_mod [2] = '{10, 16};

  typedef struct {
    string tag;
    int    sel;
    int    bin;
    bit    gm;
    bit    wrap;
    bit    lerr;
  } exp_t;

  exp_t sb[$];

  function automatic logic [3:0] exp_count(int b, bit gm);
    logic [3:0] v;
    v = b[3:0];
    return gm ? (v ^ (v >> 1)) : v;
  endfunction

  task automatic check_bit(string tag, logic obs, logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check_vec(string tag, logic [3:0] obs, logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // One clock of stimulus for instance sel. Checks tc before the edge,
  // pushes the expected post-edge state, then pops and compares it.
  task automatic cycle(int sel, bit rst, bit en, bit u, bit ld, int lv,
                       bit gm, string tag);
    logic obs_tc;
    bit   tc_e;
    int   b, m, nb;
    exp_t e;

    reset = rst;
    if (sel == 0) begin
      a_enable = en; a_up = u; a_load = ld; a_lv = lv[3:0]; a_gray = gm;
      b_enable = 1'b0; b_load = 1'b0;
    end else begin
      b_enable = en; b_up = u; b_load = ld; b_lv = lv[3:0]; b_gray = gm;
      a_enable = 1'b0; a_load = 1'b0;
    end
    #1;

    b    = m_bin[sel];
    m    = m_mod[sel];
    tc_e = en && !ld && ((u && b == m - 1) || (!u && b == 0));
    obs_tc = (sel == 0) ? a_tc : b_tc;
    check_bit({tag, " tc"}, obs_tc, tc_e);

    e.tag = tag; e.sel = sel; e.gm = gm; e.wrap = 1'b0; e.lerr = 1'b0;
    if (rst) begin
      nb = 0;
    end else if (ld) begin
      nb     = (lv < m) ? lv : 0;
      e.lerr = (lv >= m);
    end else if (en) begin
      nb     = u ? (b + 1) % m : (b + m - 1) % m;
      e.wrap = tc_e;
    end else begin
      nb = b;
    end
    if (rst) begin
      m_bin[0] = 0;
      m_bin[1] = 0;
    end else begin
      m_bin[sel] = nb;
    end
    e.bin = nb;
    sb.push_back(e);

    @(posedge clock);
    @(negedge clock);

    e = sb.pop_front();
    if (e.sel == 0) begin
      check_vec({e.tag, " count"}, a_count, exp_count(e.bin, e.gm));
      check_bit({e.tag, " wrap"}, a_wrap, e.wrap);
      check_bit({e.tag, " load_err"}, a_lerr, e.lerr);
      $display("[%0t] a %s: count=%b tc_pre=%b wrap=%b load_err=%b",
               $time, e.tag, a_count, obs_tc, a_wrap, a_lerr);
    end else begin
      check_vec({e.tag, " count"}, b_count, exp_count(e.bin, e.gm));
      check_bit({e.tag, " wrap"}, b_wrap, e.wrap);
      check_bit({e.tag, " load_err"}, b_lerr, e.lerr);
      $display("[%0t] b %s: count=%b tc_pre=%b wrap=%b load_err=%b",
               $time, e.tag, b_count, obs_tc, b_wrap, b_lerr);
    end
  endtask

  logic [3:0] up_exp   [12] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6,
                                4'd7, 4'd8, 4'd9, 4'd0, 4'd1, 4'd2};
  logic [3:0] down_exp [3]  = '{4'd9, 4'd8, 4'd7};
  logic [3:0] gray_exp [4]  = '{4'b0001, 4'b0011, 4'b0010, 4'b0110};

  initial begin
    reset = 1'b1;
    a_enable = 1'b0; a_up = 1'b1; a_load = 1'b0; a_lv = 4'd0; a_gray = 1'b0;
    b_enable = 1'b0; b_up = 1'b1; b_load = 1'b0; b_lv = 4'd0; b_gray = 1'b0;

    // Reset, even with load and enable requested.
    cycle(0, 1, 1, 1, 1, 5, 0, "reset");
    check_vec("post-reset b count", b_count, 4'd0);
    a_gray = 1'b1; #1;
    check_vec("post-reset gray count", a_count, 4'd0);
    a_gray = 1'b0; #1;

    // Up-count 12 edges across the wrap.
    for (int i = 0; i < 12; i++) begin
      cycle(0, 0, 1, 1, 0, 0, 0, "up");
      check_vec("up directed", a_count, up_exp[i]);
    end

    // Down from 0.
    cycle(0, 0, 0, 1, 1, 0, 0, "load0");
    for (int i = 0; i < 3; i++) begin
      cycle(0, 0, 1, 0, 0, 0, 0, "down");
      check_vec("down directed", a_count, down_exp[i]);
    end

    // Direction changes mid-count: 7 -> 8 -> 7 -> 8.
    cycle(0, 0, 1, 1, 0, 0, 0, "dir up");
    cycle(0, 0, 1, 0, 0, 0, 0, "dir down");
    cycle(0, 0, 1, 1, 0, 0, 0, "dir up2");

    // Load beats enable; out-of-range load clamps and flags once.
    cycle(0, 0, 1, 1, 1, 7, 0, "load7+en");
    check_vec("load7 directed", a_count, 4'd7);
    cycle(0, 0, 0, 1, 1, 12, 0, "load12");
    cycle(0, 0, 0, 1, 0, 0, 0, "hold after err");
    cycle(0, 0, 1, 0, 1, 9, 0, "load9 over tc");

    // Gray output while stepping 0..4.
    cycle(0, 0, 0, 1, 1, 0, 1, "gray load0");
    check_vec("gray 0", a_count, 4'b0000);
    for (int i = 0; i < 4; i++) begin
      cycle(0, 0, 1, 1, 0, 0, 1, "gray up");
      check_vec("gray directed", a_count, gray_exp[i]);
    end
    a_gray = 1'b0; #1;
    check_vec("gray toggle to bin", a_count, 4'd4);
    a_gray = 1'b1; #1;
    check_vec("gray toggle to gray", a_count, 4'b0110);

    // Reset while tc is high drops the pending wrap.
    cycle(0, 0, 0, 1, 1, 9, 0, "load9");
    cycle(0, 1, 1, 1, 0, 0, 0, "reset at tc");
    cycle(0, 0, 0, 1, 0, 0, 0, "hold after rst");

    // MODULUS = 2**WIDTH instance.
    cycle(1, 0, 0, 1, 1, 14, 0, "m16 load14");
    cycle(1, 0, 0, 1, 1, 15, 0, "m16 load15");
    cycle(1, 0, 1, 1, 0, 0, 0, "m16 up wrap");
    check_vec("m16 wrap directed", b_count, 4'd0);
    cycle(1, 0, 1, 1, 0, 0, 0, "m16 up");
    for (int i = 0; i < 5; i++) begin
      cycle(1, 0, 0, 1, 0, 0, 0, "m16 hold");
      check_vec("m16 hold directed", b_count, 4'd1);
    end
    cycle(1, 0, 1, 0, 0, 0, 0, "m16 down");
    cycle(1, 0, 1, 0, 0, 0, 0, "m16 down wrap");
    check_vec("m16 down wrap directed", b_count, 4'd15);
    cycle(1, 0, 1, 1, 0, 0, 1, "m16 gray up");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_mod_counter

// File: doc/mod_counter.md
MOD_COUNTER -- requirements
Module: mod_counter

Interface
REQ-001 Parameter WIDTH, default 4: counter state width in bits, legal range 2..16.
REQ-002 Parameter MODULUS, default 16: number of count states, legal range 2..2**WIDTH; count runs 0..MODULUS-1.
REQ-003 Port clock  input  1  single clock; all state changes occur on its rising edge.
REQ-004 Port reset  input  1  synchronous, active-high reset.
REQ-005 Port enable  input  1  advance count one step when high.
REQ-006 Port up  input  1  direction: 1 = increment, 0 = decrement.
REQ-007 Port load  input  1  load load_value into the counter this cycle.
REQ-008 Port load_value  input  WIDTH  binary value to load.
REQ-009 Port gray_mode  input  1  0 = count output is binary, 1 = count output is Gray-coded.
REQ-010 Port count  output  WIDTH  current count in binary or Gray, selected by gray_mode.
REQ-011 Port tc  output  1  terminal count, combinational: next enabled step wraps.
REQ-012 Port wrap  output  1  registered one-cycle pulse following a wrap.
REQ-013 Port load_err  output  1  registered one-cycle pulse following an out-of-range load.

Function
REQ-014 Internal state SHALL be a WIDTH-bit binary register bin, always holding a value in 0..MODULUS-1.
REQ-015 Per-edge priority SHALL be: reset > load > enable > hold.
REQ-016 With load=1 and load_value < MODULUS, bin SHALL take load_value at the next edge; wrap SHALL be 0.
REQ-017 With load=1 and load_value >= MODULUS, bin SHALL take 0 and load_err SHALL be 1 for exactly the next cycle.
REQ-018 With load=0, enable=1, up=1: bin SHALL go to bin+1, or to 0 when bin = MODULUS-1.
REQ-019 With load=0, enable=1, up=0: bin SHALL go to bin-1, or to MODULUS-1 when bin = 0.
REQ-020 With load=0 and enable=0, bin SHALL hold.
REQ-021 tc SHALL be enable & ~load & ((up & bin=MODULUS-1) | (~up & bin=0)).
REQ-022 wrap SHALL be 1 for exactly the cycle after an edge where tc was 1; otherwise 0.
REQ-023 count SHALL be bin when gray_mode=0, and bin ^ (bin>>1) when gray_mode=1. count is combinational from the register, so gray_mode changes take effect with zero latency.
REQ-024 A change of up while enable=1 SHALL take effect on the same edge, with no extra state and no skipped value.
REQ-025 Arithmetic SHALL be WIDTH bits wide and SHALL NOT overflow when MODULUS = 2**WIDTH.
REQ-026 Enable latency SHALL be one edge: count reflects a step in the cycle after enable is sampled high.

Reset
REQ-027 On a clock edge with reset=1, bin SHALL be 0 and wrap and load_err SHALL be 0, regardless of load or enable.
REQ-028 Reset asserted mid-count SHALL discard any pending wrap or load_err pulse.
REQ-029 In the first cycle after reset, count SHALL be 0 in both modes, and tc SHALL follow REQ-021.

Structure
REQ-030 A shared package SHALL hold the direction constants (DIR_UP=1, DIR_DOWN=0) and the output-mode constants (MODE_BIN=0, MODE_GRAY=1).
REQ-031 The design SHALL contain one combinational sub-module, bin2gray (parameter WIDTH), used for the count output path.
REQ-032 Next-state logic SHALL be a separate combinational block from the state register, mirroring the register / next-state split.

Verification (WIDTH=4, MODULUS=10 unless stated)
REQ-033 Reset, then enable=1 and up=1 for 12 edges -> count 1..9,0,1,2; tc high while bin=9; wrap pulse in the cycle count=0.
REQ-034 From 0, enable=1 and up=0 for 3 edges -> count 9,8,7; tc high at bin=0; one wrap pulse.
REQ-035 load=1 with load_value=7 and enable=1 on the same edge -> count=7, no wrap; load_value=12 -> count=0 and one load_err pulse.
REQ-036 gray_mode=1 with bin stepping 0..4 -> count 0000,0001,0011,0010,0110; toggling gray_mode changes count in the same cycle.
REQ-037 At bin=9 with tc=1, assert reset -> count=0 and no wrap pulse in the next cycle.
REQ-038 MODULUS=16: up-count from 15 -> 0 with wrap, no X or overflow; enable=0 for 5 edges -> count holds.
